// File: rtl/seg_scan_rx_if.sv
// Bundle for the observed 7-seg bus and the recovered frame.
// The master drives the display lines; the slave (receiver) reports frames.
interface seg_scan_rx_if #(
    parameter int NDIG = 4
);
    logic [7:0]        seg_in;
    logic [NDIG-1:0]   dig_an;
    logic              frame_val;
    logic [4*NDIG-1:0] frame_nib;
    logic              frame_neg;
    logic [NDIG-1:0]   frame_blank;
    logic [NDIG-1:0]   frame_dp;
    logic              frame_err;

    modport master (
        output seg_in, dig_an,
        input  frame_val, frame_nib, frame_neg, frame_blank, frame_dp, frame_err
    );

    modport slave (
        input  seg_in, dig_an,
        output frame_val, frame_nib, frame_neg, frame_blank, frame_dp, frame_err
    );
endinterface

// File: rtl/seg_scan_rx.sv
// Receiver for a multiplexed active-low 7-seg bus: waits for each digit to
// stay stable, decodes it into a shadow slot and emits whole frames.
module seg_scan_rx #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_rx_if.slave  bus
);
    localparam int        IDXW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic [7:0]      r_segMeta, r_segSync;
    logic [NDIG-1:0] r_anMeta, r_anSync;

    state_t          r_state, w_stateNext;
    logic [7:0]      r_cnt, w_cntNext;
    logic [7:0]      r_refSeg;
    logic [NDIG-1:0] r_refAn;

    logic            w_anValid, w_match, w_restart;
    logic            w_load, w_capture;
    logic [7:0]      w_capSeg;
    logic [NDIG-1:0] w_capAn, w_capMask;
    logic [IDXW-1:0] w_capIdx;

    logic [3:0]      w_decNib;
    logic            w_decNeg, w_decBlank, w_decErr, w_decDp;
    logic [6:0]      w_lit;

    logic [NDIG-1:0][3:0] r_shNib;
    logic [NDIG-1:0] r_shNeg, r_shBlank, r_shErr, r_shDp;
    logic [NDIG-1:0] r_captured;
    logic            w_allCap;

    logic              r_frameVal;
    logic [4*NDIG-1:0] r_frameNib;
    logic              r_frameNeg;
    logic [NDIG-1:0]   r_frameBlank;
    logic [NDIG-1:0]   r_frameDp;
    logic              r_frameErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segMeta <= '0;
            r_segSync <= '0;
            r_anMeta  <= '0;
            r_anSync  <= '0;
        end else begin
            r_segMeta <= bus.seg_in;
            r_segSync <= r_segMeta;
            r_anMeta  <= bus.dig_an;
            r_anSync  <= r_anMeta;
        end
    end

    assign w_anValid = $onehot(~r_anSync);
    assign w_match   = (r_anSync == r_refAn) && (r_segSync == r_refSeg);
    // HOLD falls back to IDLE handling on any change, within the same cycle
    assign w_restart = (r_state == IDLE) || ((r_state == HOLD) && !w_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_refSeg <= '0;
            r_refAn  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_load) begin
                r_refSeg <= r_segSync;
                r_refAn  <= r_anSync;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        if (w_restart) begin
            if (w_anValid) begin
                w_load      = 1'b1;
                w_cntNext   = 8'd1;
                if (STABLE_LIM == 8'd1) begin
                    w_capture   = 1'b1;
                    w_stateNext = HOLD;
                end else begin
                    w_stateNext = SETTLE;
                end
            end else begin
                w_cntNext   = '0;
                w_stateNext = IDLE;
            end
        end else if (r_state == SETTLE) begin
            if (!w_anValid) begin
                w_cntNext   = '0;
                w_stateNext = IDLE;
            end else if (!w_match) begin
                w_load    = 1'b1;
                w_cntNext = 8'd1;
                if (STABLE_LIM == 8'd1) begin
                    w_capture   = 1'b1;
                    w_stateNext = HOLD;
                end
            end else begin
                w_cntNext = r_cnt + 8'd1;
                if (w_cntNext == STABLE_LIM) begin
                    w_capture   = 1'b1;
                    w_stateNext = HOLD;
                end
            end
        end
    end

    // When the reference is being latched this cycle, capture from the live sample
    assign w_capSeg  = w_load ? r_segSync : r_refSeg;
    assign w_capAn   = w_load ? r_anSync  : r_refAn;
    assign w_capMask = ~w_capAn;
    assign w_lit     = ~w_capSeg[7:1];
    assign w_decDp   = ~w_capSeg[0];

    always_comb begin
        w_capIdx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!w_capAn[i]) begin
                w_capIdx = IDXW'(i);
            end
        end
    end

    always_comb begin
        w_decNib   = 4'h0;
        w_decNeg   = 1'b0;
        w_decBlank = 1'b0;
        w_decErr   = 1'b0;
        case (w_lit)
            7'b1111110: w_decNib = 4'h0;
            7'b0110000: w_decNib = 4'h1;
            7'b1101101: w_decNib = 4'h2;
            7'b1111001: w_decNib = 4'h3;
            7'b0110011: w_decNib = 4'h4;
            7'b1011011: w_decNib = 4'h5;
            7'b1011111: w_decNib = 4'h6;
            7'b1110000: w_decNib = 4'h7;
            7'b1111111: w_decNib = 4'h8;
            7'b1111011: w_decNib = 4'h9;
            7'b1110111: w_decNib = 4'hA;
            7'b0011111: w_decNib = 4'hB;
            7'b1001110: w_decNib = 4'hC;
            7'b0111101: w_decNib = 4'hD;
            7'b1001111: w_decNib = 4'hE;
            7'b1000111: w_decNib = 4'hF;
            7'b0000001: w_decNeg   = 1'b1;
            7'b0000000: w_decBlank = 1'b1;
            default:    w_decErr   = 1'b1;
        endcase
    end

    assign w_allCap = &r_captured;

    // A capture on the completion edge lands in the freshly cleared mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shNib      <= '0;
            r_shNeg      <= '0;
            r_shBlank    <= '0;
            r_shErr      <= '0;
            r_shDp       <= '0;
            r_captured   <= '0;
            r_frameVal   <= 1'b0;
            r_frameNib   <= '0;
            r_frameNeg   <= 1'b0;
            r_frameBlank <= '0;
            r_frameDp    <= '0;
            r_frameErr   <= 1'b0;
        end else begin
            r_frameVal <= 1'b0;
            if (w_allCap) begin
                r_frameVal   <= 1'b1;
                r_frameNib   <= r_shNib;
                r_frameNeg   <= |r_shNeg;
                r_frameBlank <= r_shBlank;
                r_frameDp    <= r_shDp;
                r_frameErr   <= |r_shErr;
            end
            if (w_capture) begin
                r_shNib[w_capIdx]   <= w_decNib;
                r_shNeg[w_capIdx]   <= w_decNeg;
                r_shBlank[w_capIdx] <= w_decBlank;
                r_shErr[w_capIdx]   <= w_decErr;
                r_shDp[w_capIdx]    <= w_decDp;
            end
            r_captured <= (w_allCap ? '0 : r_captured) | (w_capture ? w_capMask : '0);
        end
    end

    assign bus.frame_val   = r_frameVal;
    assign bus.frame_nib   = r_frameNib;
    assign bus.frame_neg   = r_frameNeg;
    assign bus.frame_blank = r_frameBlank;
    assign bus.frame_dp    = r_frameDp;
    assign bus.frame_err   = r_frameErr;
endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx: scans hand-encoded glyphs over the bus and
// checks the recovered frames against hand-computed values.
module tb_seg_scan_rx;
    localparam int NDIG = 4;

    logic clk;
    logic rst_n;
    int   testsRun  = 0;
    int   failCount = 0;
    int   valCount  = 0;
    int   startCount;

    seg_scan_rx_if #(.NDIG(NDIG)) bus ();

    seg_scan_rx #(.NDIG(NDIG), .STABLE_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_val === 1'b1) valCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg, input int cycles);
        bus.dig_an = an;
        bus.seg_in = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scanFrame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        applyStimulus(4'b1110, s0, 8);
        applyStimulus(4'b1101, s1, 8);
        applyStimulus(4'b1011, s2, 8);
        applyStimulus(4'b0111, s3, 8);
        applyStimulus(4'b1111, 8'hFF, 4);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.seg_in = 8'hFF;
        bus.dig_an = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_val",   32'(bus.frame_val),   32'h0);
        checkOutput("rst_nib",   32'(bus.frame_nib),   32'h0);
        checkOutput("rst_flags", 32'({bus.frame_neg, bus.frame_err, bus.frame_blank, bus.frame_dp}), 32'h0);
        rst_n = 1'b1;
        applyStimulus(4'hF, 8'hFF, 4);

        // 1,2,3,4
        startCount = valCount;
        scanFrame(8'h9F, 8'h25, 8'h0D, 8'h99);
        checkOutput("t1_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t1_nib",    32'(bus.frame_nib), 32'h4321);
        checkOutput("t1_neg",    32'(bus.frame_neg), 32'h0);
        checkOutput("t1_err",    32'(bus.frame_err), 32'h0);
        checkOutput("t1_blank",  32'(bus.frame_blank), 32'h0);
        checkOutput("t1_val_low", 32'(bus.frame_val), 32'h0);

        // 5,0,7,minus
        startCount = valCount;
        scanFrame(8'h49, 8'h03, 8'h1F, 8'hFD);
        checkOutput("t2_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t2_nib",    32'(bus.frame_nib), 32'h0705);
        checkOutput("t2_neg",    32'(bus.frame_neg), 32'h1);
        checkOutput("t2_blank",  32'(bus.frame_blank), 32'h0);
        checkOutput("t2_err",    32'(bus.frame_err), 32'h0);

        // 3-cycle "8" on anode 1 right before moving to anode 2
        startCount = valCount;
        applyStimulus(4'b1110, 8'h03, 8);
        applyStimulus(4'b1101, 8'h03, 8);
        applyStimulus(4'b1101, 8'h01, 3);
        applyStimulus(4'b1011, 8'h03, 8);
        applyStimulus(4'b0111, 8'h03, 8);
        applyStimulus(4'b1111, 8'hFF, 4);
        checkOutput("t3_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t3_nib",    32'(bus.frame_nib), 32'h0000);
        checkOutput("t3_neg",    32'(bus.frame_neg), 32'h0);

        // Two anodes low, then A,b,C,d
        startCount = valCount;
        applyStimulus(4'b1100, 8'h01, 10);
        checkOutput("t4_overlap_pulses", 32'(valCount - startCount), 32'd0);
        scanFrame(8'h11, 8'hC1, 8'h63, 8'h85);
        checkOutput("t4_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t4_nib",    32'(bus.frame_nib), 32'hDCBA);

        // Blank on slot 1, zeros elsewhere
        startCount = valCount;
        scanFrame(8'h03, 8'hFF, 8'h03, 8'h03);
        checkOutput("t7_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t7_blank",  32'(bus.frame_blank), 32'h2);
        checkOutput("t7_nib",    32'(bus.frame_nib), 32'h0000);

        // "0." on slot 0, undecodable on slot 2
        startCount = valCount;
        scanFrame(8'h02, 8'h9F, 8'h55, 8'h0D);
        checkOutput("t5_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t5_err",    32'(bus.frame_err), 32'h1);
        checkOutput("t5_nib",    32'(bus.frame_nib), 32'h3010);
        checkOutput("t5_dp",     32'(bus.frame_dp), 32'h1);
        checkOutput("t5_blank",  32'(bus.frame_blank), 32'h0);

        // Partial frame on slots 1..3, then reset, then full rescan
        startCount = valCount;
        applyStimulus(4'b1101, 8'h09, 8);
        applyStimulus(4'b1011, 8'h09, 8);
        applyStimulus(4'b0111, 8'h09, 8);
        bus.dig_an = 4'hF;
        bus.seg_in = 8'hFF;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_nib",   32'(bus.frame_nib), 32'h0);
        checkOutput("t6_rst_err",   32'(bus.frame_err), 32'h0);
        checkOutput("t6_rst_dp",    32'(bus.frame_dp), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'hF, 8'hFF, 4);
        applyStimulus(4'b1110, 8'h09, 8);
        applyStimulus(4'b1101, 8'h09, 8);
        applyStimulus(4'b1011, 8'h09, 8);
        checkOutput("t6_no_early_frame", 32'(valCount - startCount), 32'd0);
        applyStimulus(4'b0111, 8'h09, 8);
        applyStimulus(4'b1111, 8'hFF, 4);
        checkOutput("t6_pulses", 32'(valCount - startCount), 32'd1);
        checkOutput("t6_nib",    32'(bus.frame_nib), 32'h9999);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/seg_scan_rx.md
Name: seg_scan_rx

Overview:
- Receive-side counterpart of the seven-segment encoder: observes a multiplexed, active-low 7-seg bus (segment lines plus digit anodes) and recovers the displayed hex nibbles, sign (minus glyph), blanks and decimal points.
- Used for board loopback and self-check of the ALU display path.
- Captures one stable sample per digit, assembles a full frame, then emits it with a one-cycle valid pulse.

Parameters:
- NDIG, 4, number of multiplexed digits; anode bit i selects frame slot i.
- STABLE_CYC, 4, consecutive identical synced samples required before a digit is captured; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  8  segment lines, active-low: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp
- dig_an  input  NDIG  digit anodes, active-low, one-hot-low when valid
- frame_val  output  1  one-cycle pulse; frame outputs updated on the same edge
- frame_nib  output  4*NDIG  decoded nibble per digit; slot i at [4i+3:4i]
- frame_neg  output  1  any slot in the frame showed the minus glyph
- frame_blank  output  NDIG  slot showed no segments (a..g all off)
- frame_dp  output  NDIG  decimal point lit in slot
- frame_err  output  1  any slot in the frame held an undecodable pattern

Behaviour:
- Reset (async assert, sync-released use): all outputs 0; synchronizers, counter, shadow slots and captured mask cleared; FSM to IDLE.
- Input conditioning: seg_in and dig_an each pass through a 2-flop synchronizer. All logic below operates on synced values (s_seg, s_an).
- Glyph table (lit segments abcdefg, active-high view of ~s_seg[7:1]):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - minus=0000001 (nibble 0, sets neg); blank=0000000 (nibble 0, sets blank bit)
  - anything else: nibble 0, sets err
  - dp = ~s_seg[0], independent of glyph.
- FSM:
  - IDLE: s_an not exactly one bit low -> stay IDLE, cnt=0. One bit low -> SETTLE, latch ref_an/ref_seg, cnt=1.
  - SETTLE:
    - s_an invalid -> IDLE, cnt=0.
    - s_an != ref_an or s_seg != ref_seg -> relatch, cnt=1, stay SETTLE.
    - Otherwise cnt++. When cnt reaches STABLE_CYC, capture on that edge -> HOLD.
    - With STABLE_CYC=1, capture happens on the edge that enters SETTLE; the FSM goes directly IDLE->HOLD.
  - HOLD: no further capture while s_an==ref_an and s_seg==ref_seg. Any change -> IDLE behaviour applied that cycle, so a new valid digit enters SETTLE immediately.
- Capture: decode ref_seg into shadow slot k (k = index of low anode bit), set captured[k].
  - Recapturing a slot before frame completion overwrites it.
  - Changing segments on the same anode require a new STABLE_CYC window.
- Frame completion: on the edge after captured becomes all-ones:
  - Copy shadows to outputs.
  - frame_neg = OR of slot neg flags; frame_err = OR of slot err flags.
  - frame_val=1 for exactly one cycle; captured cleared.
  - Outputs hold until the next frame.
- A capture landing on the same edge as completion belongs to the next frame.
- Latency: anode/segment change to capture = 2 (sync) + STABLE_CYC cycles. Capture of last slot to frame_val = 1 cycle.
- Glitches shorter than STABLE_CYC synced cycles are never captured.
- Reset mid-frame discards partial frame.

Test Plan:
- Scan NDIG=4, each digit held 8 cycles, glyphs 1,2,3,4 on anodes 0..3 (segs 0x9F,0x25,0x0D,0x99) -> one frame_val pulse, frame_nib=16'h4321, neg/err/blank=0.
- Slot 3 shows minus (0xFD), others 5,0,7 -> frame_neg=1, frame_nib[15:12]=0, frame_blank=0, err=0.
- 3-cycle glitch of "8" on anode 1 inside an otherwise stable scan of 0,0,0,0 with STABLE_CYC=4 -> glitch not captured, frame_nib=16'h0000.
- Two anodes low simultaneously for 10 cycles, then normal scan of A,b,C,d -> no capture during overlap, then frame_nib=16'hDCBA.
- Undecodable pattern 0x55 on slot 2 plus dp lit on slot 0 -> frame_err=1, frame_nib[11:8]=0, frame_dp=4'b0001.
- rst_n low after 3 of 4 slots captured, then a full rescan of 9,9,9,9 -> no frame_val until the 4th slot of the new scan; frame_nib=16'h9999, outputs were 0 during reset.
